// File: rtl/laser_pkg.sv
// Shared definitions for the laser pulse sequencer: FSM state encoding,
// default sizing and clock-rate constants.
package laser_pkg;

  localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;
  localparam int unsigned DEFAULT_CNT_W  = 32;
  localparam int unsigned DEFAULT_NUM_W  = 16;
  localparam int unsigned ONE_SEC_CYCLES = DEFAULT_CLK_HZ;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    OFF   = 2'd2,
    FAULT = 2'd3
  } state_t;

endpackage

// File: rtl/laser_interval_timer.sv
// Loadable down-counter shared by the ON and OFF phases.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   load        : load load_val (priority over en)
//   load_val    : interval length minus one
//   en          : count down by one per cycle, stopping at zero
//   expire      : registered, high while the count is zero (last cycle of the interval)
module laser_interval_timer
  import laser_pkg::*;
#(
  parameter int unsigned W = DEFAULT_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;

  // Next count: load wins, otherwise count down and hold at zero
  always_comb begin
    cnt_nxt = cnt;
    if (load) begin
      cnt_nxt = load_val;
    end else if (en && (cnt != '0)) begin
      cnt_nxt = cnt - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      expire <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/laser_pulse_sequencer.sv
// Converts a start request plus on/off/count settings into a cycle-exact
// laser_en pulse train, with busy/done handshake and a sticky interlock fault.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, abort        : sequence request (IDLE only) / stop active sequence
//   fault_clr           : leave FAULT (needs interlock_ok)
//   interlock_ok        : safety chain closed
//   on_cycles, off_cycles, num_pulses : sequence settings, latched at start
//   laser_en, busy, done, fault, pulses_done : registered status outputs
module laser_pulse_sequencer
  import laser_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ,
  parameter int unsigned CNT_W  = DEFAULT_CNT_W,
  parameter int unsigned NUM_W  = DEFAULT_NUM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             fault_clr,
  input  logic             interlock_ok,
  input  logic [CNT_W-1:0] on_cycles,
  input  logic [CNT_W-1:0] off_cycles,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             laser_en,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [NUM_W-1:0] pulses_done
);

  // Clock rate only scales documentation; reject a nonsensical setting
  if (CLK_HZ == 0) begin : g_bad_clk
    $error("laser_pulse_sequencer: CLK_HZ must be non-zero");
  end

  state_t           state, state_nxt;
  logic             laser_en_nxt, busy_nxt, done_nxt, fault_nxt;
  logic [NUM_W-1:0] pulses_nxt;
  logic [CNT_W-1:0] on_lat, on_lat_nxt, off_lat, off_lat_nxt;
  logic [NUM_W-1:0] num_lat, num_lat_nxt;
  logic             tmr_load, tmr_en, tmr_expire;
  logic [CNT_W-1:0] tmr_val;

  laser_interval_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expire   (tmr_expire)
  );

  // Next-state and next-output logic; interlock beats abort beats expiry
  always_comb begin
    state_nxt    = state;
    laser_en_nxt = 1'b0;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    fault_nxt    = 1'b0;
    pulses_nxt   = pulses_done;
    on_lat_nxt   = on_lat;
    off_lat_nxt  = off_lat;
    num_lat_nxt  = num_lat;
    tmr_load     = 1'b0;
    tmr_val      = on_lat - CNT_W'(1);
    tmr_en       = (state == ON) || (state == OFF);

    unique case (state)
      IDLE: begin
        if (start) begin
          if (!interlock_ok) begin
            state_nxt = FAULT;
            fault_nxt = 1'b1;
          end else if ((num_pulses == '0) || (on_cycles == '0)) begin
            done_nxt   = 1'b1;
            pulses_nxt = '0;
          end else begin
            state_nxt    = ON;
            laser_en_nxt = 1'b1;
            busy_nxt     = 1'b1;
            pulses_nxt   = '0;
            on_lat_nxt   = on_cycles;
            off_lat_nxt  = off_cycles;
            num_lat_nxt  = num_pulses;
            tmr_load     = 1'b1;
            tmr_val      = on_cycles - CNT_W'(1);
          end
        end
      end

      ON: begin
        if (!interlock_ok) begin
          state_nxt = FAULT;
          fault_nxt = 1'b1;
        end else if (abort) begin
          state_nxt = IDLE;
        end else if (tmr_expire) begin
          if (pulses_done != '1) begin
            pulses_nxt = pulses_done + NUM_W'(1);
          end
          if (pulses_nxt >= num_lat) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            // Zero off-time is stretched to one cycle so every pulse falls
            state_nxt = OFF;
            busy_nxt  = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = (off_lat == '0) ? '0 : off_lat - CNT_W'(1);
          end
        end else begin
          laser_en_nxt = 1'b1;
          busy_nxt     = 1'b1;
        end
      end

      OFF: begin
        if (!interlock_ok) begin
          state_nxt = FAULT;
          fault_nxt = 1'b1;
        end else if (abort) begin
          state_nxt = IDLE;
        end else if (tmr_expire) begin
          state_nxt    = ON;
          laser_en_nxt = 1'b1;
          busy_nxt     = 1'b1;
          tmr_load     = 1'b1;
          tmr_val      = on_lat - CNT_W'(1);
        end else begin
          busy_nxt = 1'b1;
        end
      end

      FAULT: begin
        if (fault_clr && interlock_ok) begin
          state_nxt = IDLE;
        end else begin
          fault_nxt = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State, latched settings and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      laser_en    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      pulses_done <= '0;
      on_lat      <= '0;
      off_lat     <= '0;
      num_lat     <= '0;
    end else begin
      state       <= state_nxt;
      laser_en    <= laser_en_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      fault       <= fault_nxt;
      pulses_done <= pulses_nxt;
      on_lat      <= on_lat_nxt;
      off_lat     <= off_lat_nxt;
      num_lat     <= num_lat_nxt;
    end
  end

endmodule

// File: tb/tb_laser_pulse_sequencer.sv
// Scoreboard bench for laser_pulse_sequencer: each issued sequence pushes a
// predicted outcome; a monitor pops it when the sequence ends and compares.
`timescale 1ns/1ps
module tb_laser_pulse_sequencer;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned NUM_W = 16;

  localparam int K_DONE  = 0;
  localparam int K_ABORT = 1;
  localparam int K_FAULT = 2;

  localparam int D_NONE      = 0;
  localparam int D_ABORT     = 1;
  localparam int D_ILK       = 2;
  localparam int D_BOTH      = 3;
  localparam int D_RESET     = 4;
  localparam int D_ILK_START = 5;

  typedef struct {
    int     kind;
    longint end_cyc;
    int     pulses;
    int     high;
    int     busy;
    int     rises;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset, start, abort, fault_clr, interlock_ok;
  logic [CNT_W-1:0] on_cycles, off_cycles;
  logic [NUM_W-1:0] num_pulses;
  logic             laser_en, busy, done, fault;
  logic [NUM_W-1:0] pulses_done;

  longint cyc = 0;
  exp_t   exp_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     m_pulses = 0;

  laser_pulse_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .fault_clr    (fault_clr),
    .interlock_ok (interlock_ok),
    .on_cycles    (on_cycles),
    .off_cycles   (off_cycles),
    .num_pulses   (num_pulses),
    .laser_en     (laser_en),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .pulses_done  (pulses_done)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  function automatic int seq_len(input int on, input int off, input int num);
    int offe;
    offe = (off == 0) ? 1 : off;
    if (num == 0 || on == 0) return 0;
    return num * on + (num - 1) * offe;
  endfunction

  // Outcome from the pulse-train definition: pulse p is on during cycles
  // [p*period, p*period+on-1] counted from the cycle after start is taken.
  function automatic exp_t model(input int on, input int off, input int num,
                                 input int dk, input int x, input int prev_p,
                                 input longint c0);
    exp_t e;
    int   offe, per, len, s, lastc;
    offe = (off == 0) ? 1 : off;
    per  = on + offe;
    len  = seq_len(on, off, num);
    e.high = 0; e.busy = 0; e.rises = 0; e.pulses = 0;
    e.kind = K_DONE; e.end_cyc = c0 + 1;
    if (dk == D_ILK_START) begin
      e.kind = K_FAULT;
      e.pulses = prev_p;
    end else if (len == 0) begin
      e.kind = K_DONE;
    end else if (dk == D_NONE || x >= len) begin
      e.end_cyc = c0 + 1 + len;
      e.pulses  = num;
      e.high    = num * on;
      e.busy    = len;
      e.rises   = num;
    end else begin
      e.busy    = x + 1;
      e.end_cyc = c0 + 2 + x;
      for (int p = 0; p < num; p++) begin
        s     = p * per;
        lastc = s + on - 1;
        if (s <= x) begin
          e.rises++;
          e.high += ((lastc < x) ? lastc : x) - s + 1;
        end
        if (lastc < x) e.pulses++;
      end
      if (dk == D_ABORT) e.kind = K_ABORT;
      else if (dk == D_RESET) begin
        e.kind = K_ABORT;
        e.pulses = 0;
      end else e.kind = K_FAULT;
    end
    return e;
  endfunction

  // Monitor: accumulate activity, close a transaction on done / fault rise / busy fall
  initial begin : monitor
    int   hi, bs, rs, kind;
    logic pl, pb, pf;
    exp_t e;
    hi = 0; bs = 0; rs = 0; pl = 1'b0; pb = 1'b0; pf = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        hi += int'(laser_en);
        bs += int'(busy);
        if (laser_en && !pl) rs++;
        kind = -1;
        if (done) kind = K_DONE;
        else if (fault && !pf) kind = K_FAULT;
        else if (pb && !busy) kind = K_ABORT;
        if (kind >= 0) begin
          e = exp_q.pop_front();
          check("end_kind", kind, e.kind);
          check("end_cycle", cyc, e.end_cyc);
          check("pulses_done", pulses_done, e.pulses);
          check("laser_on_cycles", hi, e.high);
          check("busy_cycles", bs, e.busy);
          check("laser_rises", rs, e.rises);
          check("laser_off_at_end", laser_en, 0);
          hi = 0; bs = 0; rs = 0;
        end
      end else begin
        hi = 0; bs = 0; rs = 0;
      end
      pl = laser_en; pb = busy; pf = fault;
    end
  end

  task automatic clear_fault();
    @(negedge clk);
    check("fault_held", fault, 1);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("fault_clr_needs_interlock", fault, 1);
    interlock_ok = 1'b1;
    on_cycles = CNT_W'(2); num_pulses = NUM_W'(1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ignored_in_fault", {fault, busy, laser_en}, 3'b100);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("fault_cleared", fault, 0);
    check("pulses_held_after_fault", pulses_done, m_pulses);
  endtask

  task automatic run_item(input int on, input int off, input int num,
                          input int dk, input int x);
    longint c0;
    int     limit, t;
    exp_t   e;
    @(negedge clk);
    on_cycles    = CNT_W'(on);
    off_cycles   = CNT_W'(off);
    num_pulses   = NUM_W'(num);
    interlock_ok = (dk != D_ILK_START);
    start        = 1'b1;
    c0           = cyc;
    e = model(on, off, num, dk, x, m_pulses, c0);
    m_pulses = e.pulses;
    exp_q.push_back(e);
    limit = seq_len(on, off, num) + 8;
    t = 0;
    @(negedge clk);
    start = 1'b0;
    while (exp_q.size() != 0 && t <= limit) begin
      // Settings wander after start; the latched copy must govern timing
      on_cycles  = CNT_W'($urandom_range(0, 20));
      off_cycles = CNT_W'($urandom_range(0, 20));
      num_pulses = NUM_W'($urandom_range(0, 20));
      if (t == x) begin
        case (dk)
          D_ABORT: abort = 1'b1;
          D_ILK:   interlock_ok = 1'b0;
          D_BOTH:  begin abort = 1'b1; interlock_ok = 1'b0; end
          D_RESET: reset = 1'b1;
          default: ;
        endcase
      end
      @(negedge clk);
      abort = 1'b0;
      reset = 1'b0;
      t++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL seq_timeout: sequence end not seen within %0d cycles", limit);
      exp_q.delete();
    end
    if (!interlock_ok) clear_fault();
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int on, off, num, dk, x, len, r;
    reset = 1'b1; start = 1'b0; abort = 1'b0; fault_clr = 1'b0; interlock_ok = 1'b1;
    on_cycles = '0; off_cycles = '0; num_pulses = '0;
    repeat (3) @(negedge clk);
    check("rst_laser_en", laser_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_pulses_done", pulses_done, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_item(3, 2, 2, D_NONE, 0);
    run_item(3, 2, 0, D_NONE, 0);
    run_item(0, 2, 2, D_NONE, 0);
    run_item(4, 0, 3, D_NONE, 0);
    run_item(10, 2, 5, D_ILK, 14);
    run_item(3, 2, 3, D_BOTH, 2);
    run_item(3, 2, 3, D_ABORT, 4);
    run_item(5, 1, 2, D_RESET, 2);
    run_item(1, 0, 4, D_NONE, 0);
    run_item(2, 1, 2, D_ILK_START, 0);

    for (int i = 0; i < 60; i++) begin
      on  = $urandom_range(0, 5);
      off = $urandom_range(0, 3);
      num = $urandom_range(0, 4);
      r   = $urandom_range(0, 9);
      dk  = (r <= 4) ? D_NONE : (r == 5) ? D_ABORT : (r == 6) ? D_ILK :
            (r == 7) ? D_BOTH : (r == 8) ? D_RESET : D_ILK_START;
      len = seq_len(on, off, num);
      if (len == 0 && dk != D_ILK_START) dk = D_NONE;
      x = (len > 0) ? $urandom_range(0, len - 1) : 0;
      run_item(on, off, num, dk, x);
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/laser_pulse_sequencer.md
Name: laser_pulse_sequencer

Overview:
Upstream command stage for the laser head output driver. Converts a start request plus programmable on-time, off-time and pulse count into a cycle-exact laser_en pulse train. Also provides a busy/done handshake to the host controller and a sticky interlock fault path that forces the laser off. Runs on the 50 MHz system clock.

Parameters:
CLK_HZ, 50_000_000, system clock frequency; documentation and bench time scaling only.
CNT_W, 32, width of the on/off interval counters.
NUM_W, 16, width of the pulse count and progress counter.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; sampled on the clk rising edge
start  in  1  level; honoured only in IDLE
abort  in  1  level; stops an active sequence
fault_clr  in  1  clears FAULT state
interlock_ok  in  1  safety chain closed (1 = safe)
on_cycles  in  CNT_W  laser-on duration per pulse, in clk cycles
off_cycles  in  CNT_W  gap between pulses, in clk cycles
num_pulses  in  NUM_W  pulses per sequence
laser_en  out  1  registered laser head enable
busy  out  1  sequence in progress (ON or OFF)
done  out  1  one-cycle pulse at normal sequence completion
fault  out  1  high while in FAULT
pulses_done  out  NUM_W  completed pulses in current/last sequence

Behaviour:
- Reset (sync, clk edge): state=IDLE; laser_en=0, busy=0, done=0, fault=0, pulses_done=0; counters cleared. Reset mid-sequence kills the sequence with no done pulse.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, ON, OFF, FAULT.
- IDLE, start=1 sampled at edge k:
  - interlock_ok=0 -> FAULT at k+1.
  - num_pulses==0 or on_cycles==0 -> stay IDLE; done=1 for cycle k+1; laser_en stays 0; pulses_done=0.
  - Otherwise latch on/off/num into internal registers (later input changes are ignored) -> ON at k+1; pulses_done=0.
- ON: laser_en=1 and busy=1 for exactly on_cycles cycles (edges k+1 .. k+on_cycles). At expiry, pulses_done increments.
  - If the count now equals the latched num -> IDLE; laser_en=0, busy=0, and done=1 for one cycle, all at the same edge.
  - Otherwise -> OFF.
- OFF: laser_en=0, busy=1 for max(off_cycles,1) cycles, then -> ON. A zero off-time is clamped to 1 so every pulse has a falling edge.
- abort=1 in ON/OFF -> IDLE at the next edge; laser_en=0, busy=0, no done pulse; pulses_done holds its value.
- interlock_ok=0 in ON/OFF -> FAULT at the next edge; laser_en=0, busy=0, fault=1. Interlock has priority over abort and over normal expiry in the same cycle.
- FAULT: laser_en=0. Exits to IDLE only when fault_clr=1 and interlock_ok=1; fault drops at that edge. start is ignored in FAULT.
- start held high after completion re-triggers a new sequence from IDLE (level-sensitive). The host deasserts start to avoid this.
- start while busy is ignored.
- Counters: interval counters are CNT_W bits, load N-1 and count down to 0, with no wrap. pulses_done saturates at num (cannot exceed 2^NUM_W-1).
- Minimum pulse period is 2 cycles (on=1, off clamped to 1).

Decomposition:
- Package laser_pkg: state enum (IDLE, ON, OFF, FAULT), default CLK_HZ, CNT_W, NUM_W, and a ONE_SEC_CYCLES constant (CLK_HZ).
- Sub-module laser_interval_timer: loadable CNT_W down-counter with load, enable and a registered expire flag. One instance is shared by the ON and OFF phases.

Test Plan:
- Reset, then start with on=3, off=2, num=2 -> laser_en high 3 cycles, low 2, high 3. done=1 at the edge of the final fall; pulses_done=2; busy high 8 cycles.
- Start with num=0 (and separately on=0) -> laser_en never rises; done high exactly 1 cycle after start; busy stays 0.
- on=4, off=0, num=3 -> pattern 1111 0 1111 0 1111 (off clamped to 1); done after the third pulse.
- Drop interlock_ok during the second ON of on=10, num=5 -> laser_en=0 next edge; fault=1; no done. fault_clr with interlock_ok=1 -> IDLE; fault=0.
- Assert abort and interlock_ok=0 in the same cycle -> FAULT, not IDLE. Then abort alone mid-OFF of a fresh run -> IDLE, no done, pulses_done held.
- Assert reset for 1 cycle mid-ON -> all outputs 0 at the next edge. Change on_cycles mid-sequence -> no effect on the current sequence's timing.
